// File: rtl/wbi_master_port.sv
// wbi_master_port: initiator end of the valid/ready cmd/res interconnect.
// Accepts one local Wishbone master (cyc/stb with bl/bry burst extensions),
// issues cmd-channel beats and turns res-channel beats back into local
// ack/lack/err pulses. One transaction is outstanding at a time.
module wbi_master_port #(
  parameter int         AW  = 32,
  parameter int         DW  = 32,
  parameter int         BW  = 4,
  parameter int         BL  = 10,
  parameter logic [3:0] TID = 4'h0
) (
  input  logic          mclk,
  input  logic          reset_n,
  // local Wishbone master side
  input  logic          wbm_cyc_i,
  input  logic          wbm_stb_i,
  input  logic [AW-1:0] wbm_adr_i,
  input  logic          wbm_we_i,
  input  logic [DW-1:0] wbm_dat_i,
  input  logic [BW-1:0] wbm_sel_i,
  input  logic [BL-1:0] wbm_bl_i,
  input  logic          wbm_bry_i,
  output logic [DW-1:0] wbm_dat_o,
  output logic          wbm_ack_o,
  output logic          wbm_lack_o,
  output logic          wbm_err_o,
  // cmd channel
  input  logic          wbp_cmd_wrdy_i,
  output logic          wbp_cmd_wval_o,
  output logic [AW-1:0] wbp_cmd_adr_o,
  output logic          wbp_cmd_we_o,
  output logic [DW-1:0] wbp_cmd_dat_o,
  output logic [BW-1:0] wbp_cmd_sel_o,
  output logic [BL-1:0] wbp_cmd_bl_o,
  output logic [3:0]    wbp_cmd_tid_o,
  // res channel
  output logic          wbp_res_rrdy_o,
  input  logic          wbp_res_rval_i,
  input  logic [DW-1:0] wbp_res_dat_i,
  input  logic          wbp_res_ack_i,
  input  logic          wbp_res_lack_i,
  input  logic          wbp_res_err_i,
  input  logic [3:0]    wbp_res_tid_i
);

  typedef enum logic [2:0] {
    S_IDLE,   // waiting for a local cycle
    S_CMD,    // cmd beat presented, waiting for wrdy
    S_RRSP,   // read: collecting response beats
    S_WRSP,   // write: waiting for the response to the current beat
    S_WNXT,   // write burst: waiting for the next local data beat
    S_DRAIN   // local cycle abandoned: swallowing the remaining responses
  } state_t;

  state_t        state;
  logic [BL-1:0] count;      // beats still expected for this transaction
  logic          abort;      // cyc dropped while a cmd beat was pending

  // Reset: assertion reaches every flop immediately, release is retimed to mclk.
  logic [1:0] rst_sync;
  logic       rst_n;

  // Two-stage release synchroniser for the asynchronous reset input.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic          res_hs;     // response handshake this cycle
  logic          beat_hs;    // handshake carrying our transaction id
  logic          last_beat;  // this response closes the burst
  logic [BL-1:0] bl_eff;     // burst length with 0 meaning a single beat

  assign res_hs    = wbp_res_rval_i & wbp_res_rrdy_o;
  assign beat_hs   = res_hs & (wbp_res_tid_i == TID);
  assign last_beat = wbp_res_lack_i | (count == BL'(1));
  assign bl_eff    = (wbm_bl_i == '0) ? BL'(1) : wbm_bl_i;

  // Transaction FSM; every port output is a register written here.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      count          <= '0;
      abort          <= 1'b0;
      wbm_dat_o      <= '0;
      wbm_ack_o      <= 1'b0;
      wbm_lack_o     <= 1'b0;
      wbm_err_o      <= 1'b0;
      wbp_cmd_wval_o <= 1'b0;
      wbp_cmd_adr_o  <= '0;
      wbp_cmd_we_o   <= 1'b0;
      wbp_cmd_dat_o  <= '0;
      wbp_cmd_sel_o  <= '0;
      wbp_cmd_bl_o   <= '0;
      wbp_cmd_tid_o  <= 4'h0;
      wbp_res_rrdy_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge value of state/count/outputs regardless of statement order.
      wbm_ack_o  <= 1'b0;
      wbm_lack_o <= 1'b0;
      wbm_err_o  <= 1'b0;

      case (state)
        S_IDLE: begin
          wbp_res_rrdy_o <= 1'b0;
          abort          <= 1'b0;
          // A write may only start once its first data beat is valid.
          if (wbm_cyc_i && wbm_stb_i && (!wbm_we_i || wbm_bry_i)) begin
            wbp_cmd_adr_o  <= wbm_adr_i;
            wbp_cmd_we_o   <= wbm_we_i;
            wbp_cmd_dat_o  <= wbm_dat_i;
            wbp_cmd_sel_o  <= wbm_sel_i;
            wbp_cmd_bl_o   <= wbm_bl_i;
            wbp_cmd_tid_o  <= TID;
            count          <= bl_eff;
            wbp_cmd_wval_o <= 1'b1;
            state          <= S_CMD;
          end
        end

        S_CMD: begin
          wbp_res_rrdy_o <= 1'b0;
          // A presented beat cannot be withdrawn; remember the drop for later.
          if (!wbm_cyc_i) abort <= 1'b1;
          if (wbp_cmd_wval_o && wbp_cmd_wrdy_i) begin
            wbp_cmd_wval_o <= 1'b0;
            if (abort || !wbm_cyc_i) begin
              state          <= S_DRAIN;
              wbp_res_rrdy_o <= 1'b1;
            end else if (wbp_cmd_we_o) begin
              state          <= S_WRSP;
              wbp_res_rrdy_o <= 1'b1;
            end else begin
              state          <= S_RRSP;
              wbp_res_rrdy_o <= wbm_bry_i;
            end
          end
        end

        S_RRSP: begin
          if (beat_hs) begin
            count <= count - BL'(1);
            if (wbm_cyc_i) begin
              wbm_ack_o  <= wbp_res_ack_i & ~wbp_res_err_i;
              wbm_err_o  <= wbp_res_err_i;
              wbm_lack_o <= wbp_res_lack_i;
              wbm_dat_o  <= wbp_res_dat_i;
            end
          end
          if (beat_hs && last_beat) begin
            state          <= S_IDLE;
            wbp_res_rrdy_o <= 1'b0;
          end else if (!wbm_cyc_i) begin
            state          <= S_DRAIN;
            wbp_res_rrdy_o <= 1'b1;
          end else begin
            wbp_res_rrdy_o <= wbm_bry_i;
          end
        end

        S_WRSP: begin
          if (beat_hs) begin
            count <= count - BL'(1);
            if (wbm_cyc_i) begin
              wbm_ack_o  <= wbp_res_ack_i & ~wbp_res_err_i;
              wbm_err_o  <= wbp_res_err_i;
              wbm_lack_o <= wbp_res_lack_i;
            end
            // With the beat answered nothing is in flight, so a dropped
            // cycle can return straight to IDLE.
            state          <= (last_beat || !wbm_cyc_i) ? S_IDLE : S_WNXT;
            wbp_res_rrdy_o <= 1'b0;
          end else if (!wbm_cyc_i) begin
            state          <= S_DRAIN;
            wbp_res_rrdy_o <= 1'b1;
          end
        end

        S_WNXT: begin
          wbp_res_rrdy_o <= 1'b0;
          if (!wbm_cyc_i) begin
            state <= S_IDLE;
          end else if (wbm_stb_i && wbm_bry_i) begin
            wbp_cmd_dat_o  <= wbm_dat_i;
            wbp_cmd_sel_o  <= wbm_sel_i;
            wbp_cmd_wval_o <= 1'b1;
            state          <= S_CMD;
          end
        end

        S_DRAIN: begin
          wbp_res_rrdy_o <= 1'b1;
          // Reads end on lack. A write has a single beat in flight, so its
          // one response is all there is to swallow.
          if (beat_hs && (wbp_res_lack_i || wbp_cmd_we_o)) begin
            state          <= S_IDLE;
            wbp_res_rrdy_o <= 1'b0;
          end
        end

        default: begin
          state          <= S_IDLE;
          wbp_cmd_wval_o <= 1'b0;
          wbp_res_rrdy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbi_master_port.sv
// Directed testbench for wbi_master_port: the bench plays both the local
// Wishbone master and the downstream slave, with hand-computed expectations.
module tb_wbi_master_port;

  logic        mclk;
  logic        reset_n;
  logic        cyc, stb, we, bry;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic [9:0]  bl;
  logic [31:0] rdat;
  logic        ack_o, lack_o, err_o;
  logic        wrdy, wval_o;
  logic [31:0] cmd_adr, cmd_dat;
  logic        cmd_we;
  logic [3:0]  cmd_sel, cmd_tid;
  logic [9:0]  cmd_bl;
  logic        rrdy_o, rval;
  logic [31:0] res_dat;
  logic        res_ack, res_lack, res_err;
  logic [3:0]  res_tid;

  int total = 0;
  int bad   = 0;

  wbi_master_port dut (
    .mclk           (mclk),
    .reset_n        (reset_n),
    .wbm_cyc_i      (cyc),
    .wbm_stb_i      (stb),
    .wbm_adr_i      (adr),
    .wbm_we_i       (we),
    .wbm_dat_i      (wdat),
    .wbm_sel_i      (sel),
    .wbm_bl_i       (bl),
    .wbm_bry_i      (bry),
    .wbm_dat_o      (rdat),
    .wbm_ack_o      (ack_o),
    .wbm_lack_o     (lack_o),
    .wbm_err_o      (err_o),
    .wbp_cmd_wrdy_i (wrdy),
    .wbp_cmd_wval_o (wval_o),
    .wbp_cmd_adr_o  (cmd_adr),
    .wbp_cmd_we_o   (cmd_we),
    .wbp_cmd_dat_o  (cmd_dat),
    .wbp_cmd_sel_o  (cmd_sel),
    .wbp_cmd_bl_o   (cmd_bl),
    .wbp_cmd_tid_o  (cmd_tid),
    .wbp_res_rrdy_o (rrdy_o),
    .wbp_res_rval_i (rval),
    .wbp_res_dat_i  (res_dat),
    .wbp_res_ack_i  (res_ack),
    .wbp_res_lack_i (res_lack),
    .wbp_res_err_i  (res_err),
    .wbp_res_tid_i  (res_tid)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Hard stop in case a sequence step never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs are driven on the falling edge.
  task automatic tick();
    @(negedge mclk);
  endtask

  task automatic start(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [9:0] b);
    // NOTE: stimulus uses blocking assignments at the falling edge, so the
    // DUT sees stable inputs at the next rising edge with no race.
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; wdat = d; sel = 4'hf; bl = b; bry = 1'b1;
  endtask

  // Wait (bounded) for a cmd beat, check its fields, then accept it.
  task automatic cmd_accept(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [9:0] b, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (wval_o) seen = 1'b1;
      else tick();
    end
    check({tag, "_wval"}, seen, 1);
    check({tag, "_adr"}, cmd_adr, a);
    check({tag, "_we"}, cmd_we, w);
    check({tag, "_bl"}, cmd_bl, b);
    check({tag, "_tid"}, cmd_tid, 4'h0);
    if (w) check({tag, "_dat"}, cmd_dat, d);
    wrdy = 1'b1;
    tick();
    wrdy = 1'b0;
    check({tag, "_wval_drop"}, wval_o, 0);
  endtask

  // Present one response beat and hold it until rrdy_o takes it (bounded).
  // Returns at the falling edge just after the handshake edge.
  task automatic send_res(input logic [31:0] d, input logic l, input logic e,
                          input logic [3:0] t, input string tag);
    bit done = 1'b0;
    res_dat = d; res_lack = l; res_err = e; res_ack = ~e; res_tid = t; rval = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (rrdy_o) done = 1'b1;
      tick();
    end
    rval = 1'b0;
    check({tag, "_hs"}, done, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    cyc = 0; stb = 0; we = 0; bry = 0; adr = '0; wdat = '0; sel = '0; bl = '0;
    wrdy = 0; rval = 0; res_dat = '0; res_ack = 0; res_lack = 0; res_err = 0; res_tid = '0;

    // ---- reset state ----
    tick(); tick();
    check("rst_wval", wval_o, 0);
    check("rst_rrdy", rrdy_o, 0);
    check("rst_ack", ack_o, 0);
    check("rst_lack", lack_o, 0);
    check("rst_err", err_o, 0);
    check("rst_dat", rdat, 0);
    check("rst_adr", cmd_adr, 0);
    reset_n = 1'b1;
    tick(); tick(); tick();

    // ---- T1 single read ----
    start(32'h1000_0010, 1'b0, 32'h0, 10'd1);
    check("t1_wval_pre", wval_o, 0);
    tick();
    check("t1_wval_1clk", wval_o, 1);
    cmd_accept(32'h1000_0010, 1'b0, 32'h0, 10'd1, "t1");
    check("t1_rrdy", rrdy_o, 1);
    send_res(32'hDEAD_BEEF, 1'b1, 1'b0, 4'h0, "t1");
    check("t1_ack", ack_o, 1);
    check("t1_lack", lack_o, 1);
    check("t1_err", err_o, 0);
    check("t1_dat", rdat, 32'hDEAD_BEEF);
    check("t1_rrdy_idle", rrdy_o, 0);
    cyc = 0; stb = 0;
    tick();
    check("t1_ack_pulse", ack_o, 0);
    check("t1_lack_pulse", lack_o, 0);

    // ---- T2 read burst of 4 with bry stalls ----
    start(32'h2000_0000, 1'b0, 32'h0, 10'd4);
    tick();
    cmd_accept(32'h2000_0000, 1'b0, 32'h0, 10'd4, "t2");
    for (int i = 0; i < 4; i++) begin
      send_res(32'hA000_0000 + i, (i == 3), 1'b0, 4'h0, "t2_beat");
      check("t2_ack", ack_o, 1);
      check("t2_dat", rdat, 32'hA000_0000 + i);
      check("t2_lack", lack_o, (i == 3));
      if (i < 3) begin
        bry = 1'b0;
        tick();
        check("t2_rrdy_low", rrdy_o, 0);
        check("t2_ack_gap", ack_o, 0);
        res_dat = 32'hA000_0000 + i + 1; res_lack = (i + 1 == 3);
        res_err = 0; res_ack = 1; res_tid = 4'h0; rval = 1'b1;
        tick();
        check("t2_stall_noack", ack_o, 0);
        check("t2_rrdy_still_low", rrdy_o, 0);
        bry = 1'b1;
        tick();
        check("t2_rrdy_high", rrdy_o, 1);
      end
    end
    check("t2_idle_rrdy", rrdy_o, 0);
    cyc = 0; stb = 0;
    tick();
    check("t2_no_extra_ack", ack_o, 0);

    // ---- T3 write burst of 3 with a cmd stall on beat 2 ----
    start(32'h3000_0000, 1'b1, 32'h11, 10'd3);
    tick();
    cmd_accept(32'h3000_0000, 1'b1, 32'h11, 10'd3, "t3_b1");
    check("t3_rrdy_wrsp", rrdy_o, 1);
    send_res(32'h0, 1'b0, 1'b0, 4'h0, "t3_r1");
    check("t3_ack1", ack_o, 1);
    check("t3_lack1", lack_o, 0);
    wdat = 32'h22;
    tick();
    check("t3_wval2", wval_o, 1);
    check("t3_dat2", cmd_dat, 32'h22);
    wdat = 32'h99;
    for (int i = 0; i < 3; i++) begin
      check("t3_stall_wval", wval_o, 1);
      check("t3_stall_dat", cmd_dat, 32'h22);
      check("t3_stall_adr", cmd_adr, 32'h3000_0000);
      tick();
    end
    cmd_accept(32'h3000_0000, 1'b1, 32'h22, 10'd3, "t3_b2");
    send_res(32'h0, 1'b0, 1'b0, 4'h0, "t3_r2");
    check("t3_ack2", ack_o, 1);
    check("t3_lack2", lack_o, 0);
    wdat = 32'h33;
    tick();
    cmd_accept(32'h3000_0000, 1'b1, 32'h33, 10'd3, "t3_b3");
    send_res(32'h0, 1'b1, 1'b0, 4'h0, "t3_r3");
    check("t3_ack3", ack_o, 1);
    check("t3_lack3", lack_o, 1);
    cyc = 0; stb = 0;
    tick();
    check("t3_idle_wval", wval_o, 0);
    check("t3_idle_rrdy", rrdy_o, 0);

    // ---- T4 single write answered with an error ----
    start(32'h4000_0000, 1'b1, 32'h55, 10'd1);
    tick();
    cmd_accept(32'h4000_0000, 1'b1, 32'h55, 10'd1, "t4");
    send_res(32'h0, 1'b1, 1'b1, 4'h0, "t4");
    check("t4_err", err_o, 1);
    check("t4_ack", ack_o, 0);
    check("t4_lack", lack_o, 1);
    cyc = 0; stb = 0;
    tick();
    check("t4_err_pulse", err_o, 0);
    check("t4_idle_rrdy", rrdy_o, 0);

    // ---- T5 foreign tid consumed silently ----
    start(32'h5000_0000, 1'b0, 32'h0, 10'd1);
    tick();
    cmd_accept(32'h5000_0000, 1'b0, 32'h0, 10'd1, "t5");
    send_res(32'h1234_5678, 1'b1, 1'b0, 4'h5, "t5_bad");
    check("t5_bad_noack", ack_o, 0);
    check("t5_bad_nolack", lack_o, 0);
    check("t5_still_rrsp", rrdy_o, 1);
    send_res(32'hCAFE_F00D, 1'b1, 1'b0, 4'h0, "t5_good");
    check("t5_ack", ack_o, 1);
    check("t5_dat", rdat, 32'hCAFE_F00D);
    check("t5_lack", lack_o, 1);
    cyc = 0; stb = 0;
    tick();
    check("t5_idle_rrdy", rrdy_o, 0);

    // ---- T6 cyc dropped after beat 1 of a 4-beat read ----
    start(32'h6000_0000, 1'b0, 32'h0, 10'd4);
    tick();
    cmd_accept(32'h6000_0000, 1'b0, 32'h0, 10'd4, "t6");
    send_res(32'h0000_00B0, 1'b0, 1'b0, 4'h0, "t6_b1");
    check("t6_ack1", ack_o, 1);
    cyc = 0; stb = 0;
    for (int i = 1; i < 4; i++) begin
      send_res(32'h0000_00B0 + i, (i == 3), 1'b0, 4'h0, "t6_drain");
      check("t6_drain_noack", ack_o, 0);
      check("t6_drain_nolack", lack_o, 0);
    end
    check("t6_idle_rrdy", rrdy_o, 0);
    check("t6_dat_kept", rdat, 32'h0000_00B0);
    tick();
    start(32'h6100_0000, 1'b0, 32'h0, 10'd1);
    tick();
    cmd_accept(32'h6100_0000, 1'b0, 32'h0, 10'd1, "t6_next");
    send_res(32'h0000_600D, 1'b1, 1'b0, 4'h0, "t6_next");
    check("t6_next_ack", ack_o, 1);
    check("t6_next_dat", rdat, 32'h0000_600D);
    cyc = 0; stb = 0;
    tick();

    // ---- T7 reset during CMD ----
    start(32'h7000_0000, 1'b0, 32'h0, 10'd1);
    tick();
    check("t7_wval_cmd", wval_o, 1);
    reset_n = 1'b0;
    #1;
    check("t7_rst_wval", wval_o, 0);
    check("t7_rst_adr", cmd_adr, 0);
    check("t7_rst_dat", rdat, 0);
    check("t7_rst_rrdy", rrdy_o, 0);
    cyc = 0; stb = 0;
    tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    start(32'h7100_0000, 1'b0, 32'h0, 10'd1);
    tick();
    cmd_accept(32'h7100_0000, 1'b0, 32'h0, 10'd1, "t7_new");
    send_res(32'h7777_0001, 1'b1, 1'b0, 4'h0, "t7_new");
    check("t7_new_ack", ack_o, 1);
    check("t7_new_dat", rdat, 32'h7777_0001);
    cyc = 0; stb = 0;
    tick();

    // ---- T8 bl=0 behaves as a single beat ----
    start(32'h8000_0000, 1'b0, 32'h0, 10'd0);
    tick();
    cmd_accept(32'h8000_0000, 1'b0, 32'h0, 10'd0, "t8");
    send_res(32'h0000_8888, 1'b0, 1'b0, 4'h0, "t8");
    check("t8_ack", ack_o, 1);
    check("t8_lack", lack_o, 0);
    check("t8_dat", rdat, 32'h0000_8888);
    check("t8_idle_rrdy", rrdy_o, 0);
    cyc = 0; stb = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
